mem_controller: RTL and testbench
=================================

# mem_controller

Sequencer sitting directly upstream of the 16-bit word memory, between the CPU datapath and the memory's address/control pins and bidirectional data bus. Accepts one read or write request at a time over a req/ack handshake, latches address and write data into internal MAR/MWR registers, and drives the memory's enable, read_write and output_en strobes in the order the memory needs. Owns the write half of the tristate data bus and captures read data into a registered rdata output.

## Interface
- address_size, 16, width of addr and mem_address; must match the memory instance.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- req  input  1  request strobe from CPU; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  address_size  word address; sampled with req.
- wdata  input  16  write data; sampled with req.
- rdata  output  16  read result; registered, valid from the ack cycle until the next read completes.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high in every state except IDLE.
- mem_address  output  address_size  to memory address; equals MAR.
- mem_read_write  output  1  to memory read_write (1 = read).
- mem_enable  output  1  to memory enable.
- mem_output_en  output  1  to memory output_en.
- mem_data  inout  16  shared data bus to memory.

## Operation
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, DONE. Encoded as 3-bit state register; memory-side strobes are Moore decodes of state.
- IDLE: enable=0, read_write=1, output_en=0. On req=1: MAR<=addr, MWR<=wdata, go RD_ISSUE if we=0 else WR_ISSUE.
- RD_ISSUE: enable=1, read_write=1, output_en=1. Memory loads its MDR at the closing edge. Next RD_CAPTURE.
- RD_CAPTURE: strobes as RD_ISSUE (memory drives mem_data from its MDR). At closing edge rdata<=mem_data. Next DONE.
- WR_ISSUE: enable=1, read_write=0, output_en=0; mem_data driven with MWR. Memory writes at closing edge. Next DONE.
- DONE: strobes as IDLE; ack=1. Next IDLE unconditionally.
- mem_data driven by this block only in WR_ISSUE; 16'bz in all other states. Memory drives only when enable&read_write&output_en, so the two drivers are never active together.
- req, we, addr, wdata ignored in every state except IDLE; CPU may change them freely once busy=1.
- rdata unchanged by writes; retains last read value.
- Illegal state encodings go to IDLE on next edge.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, MAR=0, MWR=0, rdata=0, ack=0, busy=0, mem_enable=0, mem_read_write=1, mem_output_en=0, mem_address=0, mem_data=z. Reset mid-operation aborts the access; a write aborted in WR_ISSUE before the edge does not occur.
- Read: req sampled at edge E0 -> busy=1 after E0; RD_ISSUE E0–E1; RD_CAPTURE E1–E2; ack=1 and rdata valid E2–E3; busy=0 after E3. Latency req-edge to ack = 2 cycles, occupancy 3 cycles.
- Write: req at E0 -> WR_ISSUE E0–E1; memory updated at E1; ack=1 E1–E2. Occupancy 2 cycles.
- Back-to-back: req held high through DONE is accepted at the edge ending the IDLE cycle that follows; minimum one IDLE cycle between accesses, guaranteeing a bus-idle turnaround.
- busy is combinational from state; ack is a decode of DONE (glitch-free, registered state).

## Structure
- Shared include (mem_defs.vh): state encodings, data-width constant 16, address_size default. Memory and controller both use the width constants.
- No sub-module; single flat module (state register, MAR/MWR/rdata registers, strobe decode, tristate assign).

## Test plan
- Reset: pulse reset=0 mid-cycle with state RD_ISSUE -> all outputs at reset values immediately, mem_data=z, ack never asserts.
- Write then read: write addr=0x0012 wdata=0xBEEF, then read 0x0012 -> write ack 1 cycle after request edge; read ack 2 cycles after request edge with rdata=0xBEEF.
- Read-after-reset: read 0x0100 after memory reset -> rdata=0x0000, ack once.
- Request ignored while busy: issue read 0x0001, change addr to 0x0002 and we=1 during RD_ISSUE -> only read of 0x0001 performed, memory location 0x0002 unchanged.
- Back-to-back with req held high: writes 0x0003<=0x1111, 0x0004<=0x2222 -> each ack one cycle, at least one IDLE cycle between them, both locations correct.
- Bus contention check: monitor mem_data every cycle across mixed read/write traffic -> never X; controller drives only in WR_ISSUE.

Source files
------------

// File: rtl/mem_controller_pkg.sv
// Shared widths and sequencer state encoding for the word-memory controller.
// Imported by the controller and by anything sizing the memory bus.
package mem_controller_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_SIZE = 16;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_ISSUE   = 3'd1,
        S_RD_CAPTURE = 3'd2,
        S_WR_ISSUE   = 3'd3,
        S_DONE       = 3'd4
    } state_t;

endpackage

// File: rtl/mem_controller.sv
// Single-access sequencer between the CPU and the 16-bit word memory.
// Owns the write half of the shared data bus; memory drives it on reads.
module mem_controller
    import mem_controller_pkg::*;
#(
    parameter int address_size = ADDR_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [address_size-1:0] addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    ack,
    output logic                    busy,
    output logic [address_size-1:0] mem_address,
    output logic                    mem_read_write,
    output logic                    mem_enable,
    output logic                    mem_output_en,
    inout  wire  [DATA_W-1:0]       mem_data
);

    state_t                  state;
    logic [address_size-1:0] mar;
    logic [DATA_W-1:0]       mwr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            mar   <= '0;
            mwr   <= '0;
            rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        mar   <= addr;
                        mwr   <= wdata;
                        state <= we ? S_WR_ISSUE : S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE:   state <= S_RD_CAPTURE;
                S_RD_CAPTURE: begin
                    rdata <= mem_data;
                    state <= S_DONE;
                end
                S_WR_ISSUE:   state <= S_DONE;
                S_DONE:       state <= S_IDLE;
                default:      state <= S_IDLE;
            endcase
        end
    end

    // Strobes are pure decodes of the registered state, so they never glitch.
    always_comb begin
        mem_enable     = 1'b0;
        mem_read_write = 1'b1;
        mem_output_en  = 1'b0;
        ack            = 1'b0;
        case (state)
            S_RD_ISSUE, S_RD_CAPTURE: begin
                mem_enable    = 1'b1;
                mem_output_en = 1'b1;
            end
            S_WR_ISSUE: begin
                mem_enable     = 1'b1;
                mem_read_write = 1'b0;
            end
            S_DONE:  ack = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign mem_address = mar;
    assign mem_data    = (state == S_WR_ISSUE) ? mwr : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: behavioural word memory, shadow model
// and an ack-driven scoreboard of expected completions.
module tb_mem_controller;
    import mem_controller_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [15:0]       addr = '0;
    logic [15:0]       wdata = '0;
    logic [15:0]       rdata;
    logic              ack;
    logic              busy;
    logic [15:0]       mem_address;
    logic              mem_read_write;
    logic              mem_enable;
    logic              mem_output_en;
    wire  [15:0]       mem_data;

    typedef struct {
        bit          w;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] last_wdata = '0;
    logic [15:0] dev    [0:511];
    logic [15:0] shadow [0:511];
    logic [15:0] mdr = '0;

    mem_controller #(.address_size(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .rdata          (rdata),
        .ack            (ack),
        .busy           (busy),
        .mem_address    (mem_address),
        .mem_read_write (mem_read_write),
        .mem_enable     (mem_enable),
        .mem_output_en  (mem_output_en),
        .mem_data       (mem_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: MDR loads on read-enabled edges, array writes otherwise.
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_read_write) mdr <= dev[mem_address[8:0]];
            else                dev[mem_address[8:0]] <= mem_data;
        end
    end

    assign mem_data = (mem_enable & mem_read_write & mem_output_en)
                      ? mdr : 16'bz;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("oe_implies_rd", {31'd0, mem_output_en & ~mem_read_write}, 0);
            if (mem_enable && !mem_read_write)
                check("wr_bus", {16'd0, mem_data}, {16'd0, last_wdata});
            if (mem_enable && mem_read_write && mem_output_en)
                check("rd_bus", {16'd0, mem_data}, {16'd0, mdr});
            if (ack) begin
                if (sb.size() == 0) begin
                    check("spurious_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_cycle", cyc, e.cyc);
                    check("ack_busy", {31'd0, busy}, 1);
                    if (!e.w) check("rdata", {16'd0, rdata}, {16'd0, e.rdata});
                end
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("ack_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic access(input bit w, input logic [15:0] a,
                          input logic [15:0] d);
        exp_t e;
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        e.w     = w;
        e.rdata = shadow[a[8:0]];
        e.cyc   = cyc + (w ? 2 : 3);
        if (w) begin
            shadow[a[8:0]] = d;
            last_wdata = d;
        end
        sb.push_back(e);
        @(posedge clk);
        #1 req = 1'b0;
        wait_done();
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_ack"}, {31'd0, ack}, 0);
        check({tag, "_en"}, {31'd0, mem_enable}, 0);
        check({tag, "_rw"}, {31'd0, mem_read_write}, 1);
        check({tag, "_oe"}, {31'd0, mem_output_en}, 0);
        check({tag, "_addr"}, {16'd0, mem_address}, 0);
        check({tag, "_rdata"}, {16'd0, rdata}, 0);
    endtask

    initial begin
        exp_t e;
        int   c;
        for (int i = 0; i < 512; i++) begin
            dev[i]    = '0;
            shadow[i] = '0;
        end

        #2 expect_reset_outputs("rst");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        access(1'b0, 16'h0100, 16'h0000);
        access(1'b1, 16'h0012, 16'hBEEF);
        access(1'b0, 16'h0012, 16'h0000);
        access(1'b1, 16'h0001, 16'h5A5A);

        // Inputs wiggled while busy must not disturb the read in flight.
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        addr = 16'h0001;
        e.w = 1'b0; e.rdata = shadow[1]; e.cyc = cyc + 3;
        sb.push_back(e);
        @(posedge clk);
        #1 addr = 16'h0002; we = 1'b1; wdata = 16'hDEAD;
        @(negedge clk);
        check("mar_hold", {16'd0, mem_address}, 32'h0001);
        @(posedge clk);
        #1 req = 1'b0;
        wait_done();
        check("ignored_wr", {16'd0, dev[2]}, 0);

        // Back-to-back writes with req held high throughout.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0003; wdata = 16'h1111;
        last_wdata = 16'h1111;
        shadow[3] = 16'h1111;
        c = cyc;
        e.w = 1'b1; e.rdata = '0; e.cyc = c + 2;
        sb.push_back(e);
        @(posedge clk);
        #1 addr = 16'h0004; wdata = 16'h2222;
        @(posedge clk);
        #1 last_wdata = 16'h2222;
        shadow[4] = 16'h2222;
        e.cyc = c + 5;
        sb.push_back(e);
        @(negedge clk);
        @(negedge clk);
        check("b2b_idle_gap", {31'd0, busy}, 0);
        @(posedge clk);
        #1 req = 1'b0;
        wait_done();

        // Reset in RD_ISSUE aborts the read; no ack may follow.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'h0012;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 expect_reset_outputs("abort_rd");
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Reset in WR_ISSUE before the closing edge: memory stays untouched.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'h7777;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("abort_wr_en", {31'd0, mem_enable}, 0);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_wr_mem", {16'd0, dev[9'h020]}, 0);

        for (int i = 0; i < 20; i++) begin
            logic [15:0] a;
            logic [15:0] d;
            bit          w;
            w = 1'($urandom_range(0, 1));
            a = 16'h0030 + 16'($urandom_range(0, 7));
            d = 16'($urandom);
            access(w, a, d);
        end

        for (int i = 0; i < 64; i++)
            check("mem_final", {16'd0, dev[i]}, {16'd0, shadow[i]});
        check("mem_final_100", {16'd0, dev[9'h100]}, {16'd0, shadow[9'h100]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout obs=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
